// File: rtl/piso_shift_pkg.sv
// Shared types and helpers for the piso_shift parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int unsigned PISO_DEFAULT_W = 16;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return 32'($clog2(n + 1));
    endfunction

endpackage

// File: rtl/piso_shift_if.sv
// Load and serial handshake bundle for piso_shift; master is the producer/consumer side.
interface piso_shift_if
    import piso_pkg::*;
#(
    parameter int unsigned N = PISO_DEFAULT_W
);
    logic         LOAD_VALID;
    logic         LOAD_READY;
    logic [N-1:0] D;
    logic         SOUT;
    logic         SVALID;
    logic         SREADY;
    logic         BUSY;
    logic         DONE;

    modport master (
        output LOAD_VALID, D, SREADY,
        input  LOAD_READY, SOUT, SVALID, BUSY, DONE
    );

    modport slave (
        input  LOAD_VALID, D, SREADY,
        output LOAD_READY, SOUT, SVALID, BUSY, DONE
    );
endinterface

// File: rtl/piso_shift_bit_counter.sv
// Beat counter for piso_shift: clear has priority over increment, LAST flags the final beat.
module bit_counter #(
    parameter int unsigned TOTAL = 16,
    parameter int unsigned W     = 5
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         CLEAR,
    input  logic         INC,
    output logic [W-1:0] COUNT,
    output logic         LAST
);
    logic [W-1:0] r_count;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
        end else if (CLEAR) begin
            r_count <= '0;
        end else if (INC) begin
            r_count <= r_count + W'(1);
        end
    end

    assign COUNT = r_count;
    assign LAST  = (r_count == W'(TOTAL - 1));
endmodule

// File: rtl/piso_shift.sv
// Parallel-in/serial-out transmitter: one word in via load handshake, one bit out per serial beat.
// Define PISO_PARITY_EN to append an even-parity beat after the data bits.
module piso_shift
    import piso_pkg::*;
#(
    parameter int unsigned N         = PISO_DEFAULT_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    piso_shift_if.slave bus
);
`ifdef PISO_PARITY_EN
    localparam int unsigned TOTAL = N + 1;
`else
    localparam int unsigned TOTAL = N;
`endif
    localparam int unsigned CW = cnt_width(TOTAL);

    piso_state_t   r_state;
    piso_state_t   w_next_state;
    logic [N-1:0]  r_shreg;
    logic [N-1:0]  w_shreg_shifted;
    logic          r_done;
    logic [CW-1:0] w_count;
    logic          w_last;
    logic          w_shifting;
    logic          w_beat;
    logic          w_load_ready;
    logic          w_load;
    logic          w_data_bit;
    logic          w_sout;

    assign w_shifting   = (r_state == SHIFT);
    assign w_beat       = w_shifting & bus.SREADY;
    // Reload is allowed on the last accepted beat so consecutive words leave no idle bubble.
    assign w_load_ready = ~RESET & (~w_shifting | (w_last & bus.SREADY));
    assign w_load       = bus.LOAD_VALID & w_load_ready;

    bit_counter #(
        .TOTAL (TOTAL),
        .W     (CW)
    ) u_bit_counter (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .CLEAR (w_load),
        .INC   (w_beat),
        .COUNT (w_count),
        .LAST  (w_last)
    );

    // State register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next_state = SHIFT;
            SHIFT:   if (w_beat && w_last && !w_load) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_shreg_shifted = MSB_FIRST ? {r_shreg[N-2:0], 1'b0} : {1'b0, r_shreg[N-1:1]};
    assign w_data_bit      = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];

    // Shift register and end-of-word pulse.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_shreg <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_beat & w_last;
            if (w_load) begin
                r_shreg <= bus.D;
            end else if (w_beat) begin
                r_shreg <= w_shreg_shifted;
            end
        end
    end

`ifdef PISO_PARITY_EN
    logic r_parity;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^bus.D;
        end
    end

    // Beat index N is the parity beat; the data bits are exhausted by then.
    assign w_sout = (w_count == CW'(N)) ? r_parity : w_data_bit;
`else
    logic w_unused_count;

    assign w_unused_count = ^w_count;
    assign w_sout         = w_data_bit;
`endif

    assign bus.LOAD_READY = w_load_ready;
    assign bus.SOUT       = w_sout;
    assign bus.SVALID     = w_shifting;
    assign bus.BUSY       = w_shifting;
    assign bus.DONE       = r_done;
endmodule

// File: tb/tb_piso_shift.sv
// Bench for piso_shift: serial bits checked against a scoreboard queue filled at load time.
module tb_piso_shift;
    import piso_pkg::*;

    localparam int unsigned W = 16;
`ifdef PISO_PARITY_EN
    localparam int TOTI = int'(W) + 1;
`else
    localparam int TOTI = int'(W);
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_a  = 0;
    int beats_b  = 0;
    bit qa[$];
    bit qb[$];
    bit exp_a;
    bit exp_b;

    piso_shift_if #(.N(W)) bus_a ();
    piso_shift_if #(.N(W)) bus_b ();

    piso_shift #(.N(W), .MSB_FIRST(1'b1)) u_dut_a (
        .CLOCK (clk),
        .RESET (rst_a),
        .bus   (bus_a)
    );

    piso_shift #(.N(W), .MSB_FIRST(1'b0)) u_dut_b (
        .CLOCK (clk),
        .RESET (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference bit order; DUT A is MSB-first, DUT B is LSB-first.
    function automatic void push_word(input bit to_b, input logic [W-1:0] d);
        bit b;
        for (int i = 0; i < int'(W); i++) begin
            b = to_b ? d[i] : d[int'(W) - 1 - i];
            if (to_b) qb.push_back(b);
            else      qa.push_back(b);
        end
`ifdef PISO_PARITY_EN
        if (to_b) qb.push_back(^d);
        else      qa.push_back(^d);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every accepted serial beat pops one expected bit.
    always @(negedge clk) begin
        if (rst_a === 1'b0 && bus_a.SVALID === 1'b1 && bus_a.SREADY === 1'b1) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a_extra: beat %0d SOUT=%b but no bit expected", beats_a, bus_a.SOUT);
            end else begin
                exp_a = qa.pop_front();
                if (bus_a.SOUT !== exp_a) begin
                    n_fail++;
                    $display("FAIL sb_a_bit: beat %0d SOUT=%b expected %b", beats_a, bus_a.SOUT, exp_a);
                end
            end
            beats_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_b === 1'b0 && bus_b.SVALID === 1'b1 && bus_b.SREADY === 1'b1) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b_extra: beat %0d SOUT=%b but no bit expected", beats_b, bus_b.SOUT);
            end else begin
                exp_b = qb.pop_front();
                if (bus_b.SOUT !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_b_bit: beat %0d SOUT=%b expected %b", beats_b, bus_b.SOUT, exp_b);
                end
            end
            beats_b++;
        end
    end

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'h5A5A;
        bus_a.SREADY     = 1'b1;
        bus_b.LOAD_VALID = 1'b0;
        bus_b.D          = '0;
        bus_b.SREADY     = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus_a.SOUT, bus_a.SVALID, bus_a.BUSY, bus_a.DONE, bus_a.LOAD_READY} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a: {SOUT,SVALID,BUSY,DONE,LOAD_READY}=%b expected 00000",
                     {bus_a.SOUT, bus_a.SVALID, bus_a.BUSY, bus_a.DONE, bus_a.LOAD_READY});
        end
        n_checks++;
        if ({bus_b.SOUT, bus_b.SVALID, bus_b.BUSY, bus_b.DONE, bus_b.LOAD_READY} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_b: {SOUT,SVALID,BUSY,DONE,LOAD_READY}=%b expected 00000",
                     {bus_b.SOUT, bus_b.SVALID, bus_b.BUSY, bus_b.DONE, bus_b.LOAD_READY});
        end
        tick();
        bus_a.LOAD_VALID = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.LOAD_READY, bus_b.LOAD_READY, bus_a.SVALID, bus_b.SVALID} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_release: {RDY_A,RDY_B,SV_A,SV_B}=%b expected 1100",
                     {bus_a.LOAD_READY, bus_b.LOAD_READY, bus_a.SVALID, bus_b.SVALID});
        end
    endtask

    task automatic test_single_msb();
        int b0;
        int bad;
        b0  = beats_a;
        bad = 0;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'hA5C3;
        push_word(1'b0, 16'hA5C3);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        bus_a.D          = 16'hFFFF;
        for (int c = 0; c < TOTI; c++) begin
            @(negedge clk);
            if (bus_a.SVALID !== 1'b1 || bus_a.BUSY !== 1'b1 || bus_a.DONE !== 1'b0) bad++;
            tick();
            bus_a.D = 16'($urandom);
        end
        @(negedge clk);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL single_busy: %0d shift cycles with wrong SVALID/BUSY/DONE, expected 0", bad);
        end
        n_checks++;
        if ({bus_a.DONE, bus_a.BUSY, bus_a.SVALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_done: {DONE,BUSY,SVALID}=%b expected 100",
                     {bus_a.DONE, bus_a.BUSY, bus_a.SVALID});
        end
        n_checks++;
        if (beats_a - b0 != TOTI || qa.size() != 0) begin
            n_fail++;
            $display("FAIL single_beats: beats=%0d left=%0d expected %0d and 0", beats_a - b0, qa.size(), TOTI);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus_a.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse: DONE=%b expected 0 one cycle later", bus_a.DONE);
        end
    endtask

    task automatic test_lsb_first();
        int  b0;
        logic first_bit;
        b0 = beats_b;
        first_bit = 1'b0;
        tick();
        bus_b.LOAD_VALID = 1'b1;
        bus_b.D          = 16'h0001;
        push_word(1'b1, 16'h0001);
        tick();
        bus_b.LOAD_VALID = 1'b0;
        for (int c = 0; c < TOTI; c++) begin
            @(negedge clk);
            if (c == 0) first_bit = bus_b.SOUT;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (first_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_first_bit: first SOUT=%b expected 1", first_bit);
        end
        n_checks++;
        if (bus_b.DONE !== 1'b1 || beats_b - b0 != TOTI) begin
            n_fail++;
            $display("FAIL lsb_done: DONE=%b beats=%0d expected 1 and %0d", bus_b.DONE, beats_b - b0, TOTI);
        end
    endtask

    task automatic test_backpressure();
        int   b0;
        int   seen;
        int   cyc;
        int   early;
        int   hold_err;
        bit   prev_stall;
        logic prev_sout;
        b0         = beats_a;
        seen       = 0;
        cyc        = 0;
        early      = 0;
        hold_err   = 0;
        prev_stall = 1'b0;
        prev_sout  = 1'b0;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'hFFFF;
        push_word(1'b0, 16'hFFFF);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        bus_a.SREADY     = 1'b1;
        while (seen < TOTI && cyc < 200) begin
            @(negedge clk);
            if (bus_a.DONE !== 1'b0) early++;
            if (bus_a.SVALID !== 1'b1) hold_err++;
            if (prev_stall && bus_a.SOUT !== prev_sout) hold_err++;
            if (bus_a.SREADY === 1'b1) seen++;
            prev_stall = (bus_a.SREADY === 1'b0);
            prev_sout  = bus_a.SOUT;
            tick();
            cyc++;
            bus_a.SREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end
        bus_a.SREADY = 1'b1;
        @(negedge clk);
        n_checks++;
        if (seen != TOTI || beats_a - b0 != TOTI) begin
            n_fail++;
            $display("FAIL bp_beats: seen=%0d scoreboard=%0d expected %0d", seen, beats_a - b0, TOTI);
        end
        n_checks++;
        if (hold_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d stall cycles changed SOUT/SVALID, expected 0", hold_err);
        end
        n_checks++;
        if (early != 0 || bus_a.DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: early=%0d DONE=%b expected 0 and 1", early, bus_a.DONE);
        end
    endtask

    task automatic test_back_to_back();
        int b0;
        int gaps;
        int ndone;
        int d1;
        int d2;
        b0    = beats_a;
        gaps  = 0;
        ndone = 0;
        d1    = -1;
        d2    = -1;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'h8000;
        push_word(1'b0, 16'h8000);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        bus_a.D          = '0;
        for (int c = 0; c <= 2 * TOTI; c++) begin
            @(negedge clk);
            if (c < 2 * TOTI && bus_a.SVALID !== 1'b1) gaps++;
            if (c == TOTI - 2) begin
                n_checks++;
                if (bus_a.LOAD_READY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_early: LOAD_READY=%b expected 0 before last beat", bus_a.LOAD_READY);
                end
            end
            if (c == TOTI - 1) begin
                n_checks++;
                if (bus_a.LOAD_READY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_last: LOAD_READY=%b expected 1 on last beat", bus_a.LOAD_READY);
                end
            end
            if (bus_a.DONE === 1'b1) begin
                ndone++;
                if (d1 < 0) d1 = c;
                else        d2 = c;
            end
            tick();
            if (c + 1 == TOTI - 1) begin
                bus_a.LOAD_VALID = 1'b1;
                bus_a.D          = 16'h0001;
                push_word(1'b0, 16'h0001);
            end else begin
                bus_a.LOAD_VALID = 1'b0;
            end
        end
        n_checks++;
        if (gaps != 0 || beats_a - b0 != 2 * TOTI) begin
            n_fail++;
            $display("FAIL b2b_stream: gaps=%0d beats=%0d expected 0 and %0d", gaps, beats_a - b0, 2 * TOTI);
        end
        n_checks++;
        if (ndone != 2 || d1 != TOTI || d2 != 2 * TOTI) begin
            n_fail++;
            $display("FAIL b2b_done: count=%0d at %0d,%0d expected 2 at %0d,%0d", ndone, d1, d2, TOTI, 2 * TOTI);
        end
    endtask

    task automatic test_reset_midword();
        int b0;
        b0 = beats_a;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'h1234;
        push_word(1'b0, 16'h1234);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        repeat (5) tick();
        rst_a = 1'b1;
        qa.delete();
        #1;
        n_checks++;
        if (beats_a - b0 != 5) begin
            n_fail++;
            $display("FAIL rst_mid_beats: beats before reset=%0d expected 5", beats_a - b0);
        end
        n_checks++;
        if ({bus_a.SOUT, bus_a.SVALID, bus_a.BUSY, bus_a.DONE} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: {SOUT,SVALID,BUSY,DONE}=%b expected 0000",
                     {bus_a.SOUT, bus_a.SVALID, bus_a.BUSY, bus_a.DONE});
        end
        tick();
        rst_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_a.DONE !== 1'b0 || bus_a.LOAD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_release: DONE=%b LOAD_READY=%b expected 0 and 1", bus_a.DONE, bus_a.LOAD_READY);
        end
        b0 = beats_a;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'h00FF;
        push_word(1'b0, 16'h00FF);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        repeat (TOTI) tick();
        @(negedge clk);
        n_checks++;
        if (bus_a.DONE !== 1'b1 || beats_a - b0 != TOTI || qa.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_reload: DONE=%b beats=%0d left=%0d expected 1, %0d, 0",
                     bus_a.DONE, beats_a - b0, qa.size(), TOTI);
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic par_bit;
        par_bit = 1'b0;
        tick();
        bus_a.LOAD_VALID = 1'b1;
        bus_a.D          = 16'h0007;
        push_word(1'b0, 16'h0007);
        tick();
        bus_a.LOAD_VALID = 1'b0;
        for (int c = 0; c < TOTI; c++) begin
            @(negedge clk);
            if (c == int'(W)) par_bit = bus_a.SOUT;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (par_bit !== 1'b1 || bus_a.DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_beat: parity SOUT=%b DONE=%b expected 1 and 1", par_bit, bus_a.DONE);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_msb();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_midword();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        repeat (2) tick();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d expected bits never transmitted, expected 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_shift.md
Name: piso_shift

Overview:
- Parallel-in/serial-out transmitter for the 16-bit datapath.
- A register captures a whole word at once; this block does the reverse. It accepts one N-bit word through a valid/ready load handshake, then emits it one bit per accepted beat on a serial valid/ready stream.
- Used wherever a datapath word leaves the core over a 1-bit link, such as a debug or UART-style output.

Parameters:
- N, 16, word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = bit N-1 sent first; 0 = bit 0 sent first.

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LOAD_VALID  input  1  producer offers D.
- LOAD_READY  output  1  block accepts D this cycle.
- D  input  N  parallel word to transmit.
- SOUT  output  1  current serial bit.
- SVALID  output  1  SOUT holds a valid bit.
- SREADY  input  1  consumer accepts SOUT this cycle.
- BUSY  output  1  a word is in flight.
- DONE  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE; shift register=0; bit counter=0.
  - SOUT=0, SVALID=0, BUSY=0, DONE=0.
  - LOAD_READY=1 while RESET is low and state=IDLE.
- Handshakes:
  - Load transfer = LOAD_VALID & LOAD_READY.
  - Serial beat = SVALID & SREADY.
- States:
  - IDLE: LOAD_READY=1, SVALID=0, BUSY=0. On a load transfer, capture D into the shift register, set counter=0, and go to SHIFT on the next edge.
  - SHIFT: SVALID=1, BUSY=1. SOUT = shreg[N-1] if MSB_FIRST, else shreg[0], driven combinationally from the register. On each beat, shift by one toward the output end (zero fill) and increment the counter.
- Counter: width $clog2(N+1). "Last" means counter == TOTAL-1, where TOTAL=N (N+1 with PARITY_EN).
- Last beat in SHIFT:
  - DONE=1 on the following cycle only.
  - Next state is IDLE, unless LOAD_VALID is also high that cycle.
- Back-to-back reload:
  - LOAD_READY = (state==IDLE) | (state==SHIFT & last & SREADY).
  - A load accepted on the last-beat cycle reloads the shift register, clears the counter and stays in SHIFT, so there is no idle bubble. DONE still pulses for the finished word.
- Backpressure: while SREADY=0 in SHIFT, SOUT, SVALID, the shift register and the counter all hold. LOAD_VALID is ignored, since LOAD_READY=0.
- Latency: first bit valid on the cycle after the load transfer. With SREADY held high, a word occupies exactly TOTAL cycles in SHIFT.
- RESET asserted mid-word: the word is discarded immediately. Outputs go to reset values with no DONE pulse.
- D is sampled only on a load transfer; changes to D at other times have no effect.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - After the N data bits, one extra beat carries the even-parity bit, i.e. the XOR of the captured word, computed at load and stored in a flop.
  - TOTAL=N+1; DONE follows the parity beat.
- Undefined:
  - No parity logic or flop.
  - TOTAL=N.

Decomposition:
- Shared package piso_pkg:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - localparam default width 16.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module bit_counter(CLOCK, RESET, CLEAR, INC, COUNT, LAST). LAST compares COUNT against a TOTAL parameter.
- The shift register and FSM stay in piso_shift.

Test Plan:
- Single word, SREADY=1, MSB_FIRST=1, D=16'hA5C3 loaded at t0 -> SOUT over the next 16 cycles = 1010010111000011. DONE pulses on cycle 17. BUSY drops the same cycle.
- MSB_FIRST=0, D=16'h0001 -> the first SOUT beat is 1, the remaining 15 are 0. DONE after 16 beats.
- Backpressure, D=16'hFFFF: SREADY toggles 1,0,0,1,... -> SOUT/SVALID held during the 0 cycles. Exactly 16 beats counted. DONE only after the 16th accepted beat.
- Back-to-back: D=16'h8000 then D=16'h0001 offered on the last-beat cycle -> LOAD_READY=1 that cycle. 32 contiguous beats with no SVALID gap. DONE pulses twice, 16 cycles apart.
- RESET asserted after the 5th beat of 16'h1234 -> SVALID=0, BUSY=0 immediately with no DONE. The next load of 16'h00FF transmits cleanly from bit 15.
- PISO_PARITY_EN defined, D=16'h0007 -> 16 data beats, then a 17th beat SOUT=1 (odd count of ones). DONE after beat 17.
